main_memory_responder: RTL and testbench

Responder end of the cache-to-main-memory link. Serves 64-byte line refills and dirty-line write-backs issued by the 4-way set-associative cache controller, with a programmable access latency. Holds the backing store as 64-bit words and moves each line as an 8-beat burst. `MM_ready` high is the cache's cue to proceed with a burst.

---
 rtl/cache_pkg.sv | 50 +++++
 rtl/mm_storage.sv | 27 ++
 rtl/main_memory_responder.sv | 134 +++++++++++++
 tb/tb_main_memory_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller and its main-memory responder:
// line geometry, address-field positions and the responder state encoding.
package cache_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int BEATS      = 8;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int BEAT_W     = $clog2(BEATS);

  localparam int OFFSET_LSB = 0;
  localparam int OFFSET_MSB = 5;
  localparam int INDEX_LSB  = 6;
  localparam int INDEX_MSB  = 12;
  localparam int TAG_LSB    = 13;
  localparam int TAG_MSB    = 31;

  // Line number = every address bit above the byte offset.
  localparam int LINE_W = ADDR_W - (OFFSET_MSB + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST,
    DONE
  } mm_state_t;

  typedef struct packed {
    logic ready;
    logic rvalid;
    logic done;
    logic busy;
  } mm_flags_t;

  // Moore output decode, evaluated on the next state so the flags are registered.
  function automatic mm_flags_t mm_flags(mm_state_t s);
    mm_flags_t f;
    f.ready  = (s == RD_BURST) || (s == WR_BURST);
    f.rvalid = (s == RD_BURST);
    f.done   = (s == DONE);
    f.busy   = (s != IDLE);
    return f;
  endfunction

  function automatic mm_state_t burst_state(logic we);
    return we ? WR_BURST : RD_BURST;
  endfunction

endpackage

// File: rtl/mm_storage.sv
// Single-port backing store: synchronous write, combinational read, shared address.
module mm_storage
  import cache_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int WORD_AW   = $clog2(MEM_WORDS)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [WORD_AW-1:0] addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // NOTE: the array has no reset; clearing thousands of words would need a
  // reset fan-out to every bit and would stop the array mapping onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/main_memory_responder.sv
// Responder for 64-byte line refills and write-backs: programmable latency,
// then an 8-beat burst, then a one-cycle done pulse.
module main_memory_responder
  import cache_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mm_req,
  input  logic              mm_we,
  input  logic [ADDR_W-1:0] mm_addr,
  input  logic [DATA_W-1:0] mm_wdata,
  input  logic              mm_wvalid,
  output logic              MM_ready,
  output logic [DATA_W-1:0] mm_rdata,
  output logic              mm_rvalid,
  output logic              mm_done,
  output logic              busy
);

  localparam int WORD_AW = $clog2(MEM_WORDS);
  localparam int LAT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_INIT = (LATENCY > 0) ? LATENCY - 1 : 0;

  mm_state_t         state;
  mm_flags_t         flags_q;
  logic [LINE_W-1:0] line_q;
  logic              we_q;
  logic [LAT_W-1:0]  lat_cnt;
  logic [BEAT_W-1:0] beat_q;

  logic [WORD_AW-1:0] word_idx;
  logic [DATA_W-1:0]  stor_rdata;
  logic               stor_we;
  logic               last_beat;

  // Dropping the upper line bits makes addresses wrap onto the store.
  assign word_idx  = WORD_AW'({line_q, beat_q});
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign stor_we   = (state == WR_BURST) && mm_wvalid;

  // Offset bits select a byte inside the line and play no part here.
  wire unused_offset = &{1'b0, mm_addr[OFFSET_MSB:OFFSET_LSB]};

  mm_storage #(
    .MEM_WORDS (MEM_WORDS)
  ) u_storage (
    .clk   (clk),
    .we    (stor_we),
    .addr  (word_idx),
    .wdata (mm_wdata),
    .rdata (stor_rdata)
  );

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // mixing in blocking writes would make later reads in this block see new values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      flags_q <= '0;
      line_q  <= '0;
      we_q    <= 1'b0;
      lat_cnt <= '0;
      beat_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mm_req) begin
            line_q <= mm_addr[ADDR_W-1:OFFSET_MSB+1];
            we_q   <= mm_we;
            beat_q <= '0;
            if (LATENCY > 0) begin
              lat_cnt <= LAT_W'(LAT_INIT);
              state   <= WAIT;
              flags_q <= mm_flags(WAIT);
            end else begin
              state   <= burst_state(mm_we);
              flags_q <= mm_flags(burst_state(mm_we));
            end
          end
        end

        WAIT: begin
          if (lat_cnt == '0) begin
            state   <= burst_state(we_q);
            flags_q <= mm_flags(burst_state(we_q));
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        RD_BURST: begin
          beat_q <= beat_q + 1'b1;
          if (last_beat) begin
            state   <= DONE;
            flags_q <= mm_flags(DONE);
          end
        end

        // A beat without mm_wvalid is a stall: nothing written, counter held.
        WR_BURST: begin
          if (mm_wvalid) begin
            beat_q <= beat_q + 1'b1;
            if (last_beat) begin
              state   <= DONE;
              flags_q <= mm_flags(DONE);
            end
          end
        end

        DONE: begin
          state   <= IDLE;
          flags_q <= mm_flags(IDLE);
        end

        default: begin
          state   <= IDLE;
          flags_q <= mm_flags(IDLE);
        end
      endcase
    end
  end

  assign MM_ready  = flags_q.ready;
  assign mm_rvalid = flags_q.rvalid;
  assign mm_done   = flags_q.done;
  assign busy      = flags_q.busy;

  // Data is gated so the bus reads zero outside a refill and under reset.
  assign mm_rdata  = flags_q.rvalid ? stor_rdata : '0;

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench: two responders (LATENCY 4 and 0) driven by refill and
// write-back tasks against a reference copy of the backing store.
module tb_main_memory_responder;
  import cache_pkg::*;

  localparam int MEM_WORDS = 4096;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mm_req    [2];
  logic        mm_we     [2];
  logic [31:0] mm_addr   [2];
  logic [63:0] mm_wdata  [2];
  logic        mm_wvalid [2];
  logic        MM_ready  [2];
  logic [63:0] mm_rdata  [2];
  logic        mm_rvalid [2];
  logic        mm_done   [2];
  logic        busy      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    main_memory_responder #(
      .LATENCY   ((g == 0) ? 4 : 0),
      .MEM_WORDS (MEM_WORDS)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .mm_req    (mm_req[g]),
      .mm_we     (mm_we[g]),
      .mm_addr   (mm_addr[g]),
      .mm_wdata  (mm_wdata[g]),
      .mm_wvalid (mm_wvalid[g]),
      .MM_ready  (MM_ready[g]),
      .mm_rdata  (mm_rdata[g]),
      .mm_rvalid (mm_rvalid[g]),
      .mm_done   (mm_done[g]),
      .busy      (busy[g])
    );
  end

  logic [63:0] model [2][MEM_WORDS];
  logic [63:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  function automatic int widx(input logic [31:0] addr, input int k);
    longint w;
    w = longint'(addr >> 6) * 8 + longint'(k);
    return int'(w % MEM_WORDS);
  endfunction

  task automatic wait_idle(input int d);
    int i;
    i = 0;
    @(negedge clk);
    while (busy[d] && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (busy[d]) check("idle_timeout", 64'(busy[d]), 64'd0);
  endtask

  task automatic refill(input int d, input logic [31:0] addr, input string tag);
    int  lat;
    bit  in_burst;
    lat = lat_of(d);
    for (int k = 0; k < 8; k++) exp_q.push_back(model[d][widx(addr, k)]);
    wait_idle(d);
    mm_req[d]  = 1'b1;
    mm_we[d]   = 1'b0;
    mm_addr[d] = addr;
    @(posedge clk);
    #1;
    // Request kept high and address/direction scrambled: all must be ignored.
    mm_addr[d] = ~addr;
    mm_we[d]   = 1'b1;
    for (int n = 1; n <= lat + 9; n++) begin
      @(negedge clk);
      in_burst = (n >= lat + 1) && (n <= lat + 8);
      check({tag, "_ready"},  64'(MM_ready[d]),  64'(in_burst));
      check({tag, "_rvalid"}, 64'(mm_rvalid[d]), 64'(in_burst));
      check({tag, "_done"},   64'(mm_done[d]),   64'(n == lat + 9));
      check({tag, "_busy"},   64'(busy[d]),      64'd1);
      if (mm_rvalid[d]) begin
        if (exp_q.size() == 0) check({tag, "_extra_beat"}, 64'd1, 64'd0);
        else check({tag, "_data"}, mm_rdata[d], exp_q.pop_front());
      end
      if (n == lat + 9) begin
        mm_req[d] = 1'b0;
        mm_we[d]  = 1'b0;
      end
    end
    while (exp_q.size() > 0) check({tag, "_missing_beat"}, 64'd0, exp_q.pop_front());
    @(negedge clk);
    check({tag, "_done_after"}, 64'(mm_done[d]), 64'd0);
    check({tag, "_idle_after"}, 64'(busy[d]),    64'd0);
  endtask

  task automatic writeback(input int d, input logic [31:0] addr, input logic [63:0] base,
                           input int stall_at, input int stall_len, input int abort_at,
                           input string tag);
    int lat, k, stalls, last;
    bit in_burst;
    lat = lat_of(d);
    k = 0;
    stalls = 0;
    last = lat + 9 + ((stall_at >= 0) ? stall_len : 0);
    wait_idle(d);
    mm_req[d]    = 1'b1;
    mm_we[d]     = 1'b1;
    mm_addr[d]   = addr;
    mm_wvalid[d] = 1'b1;
    mm_wdata[d]  = JUNK;
    @(posedge clk);
    #1;
    mm_addr[d] = ~addr;
    mm_we[d]   = 1'b0;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      in_burst = (n >= lat + 1) && (n < last);
      check({tag, "_ready"},  64'(MM_ready[d]),  64'(in_burst));
      check({tag, "_rvalid"}, 64'(mm_rvalid[d]), 64'd0);
      check({tag, "_done"},   64'(mm_done[d]),   64'(n == last));
      if (in_burst) begin
        if (k == abort_at) begin
          mm_wvalid[d] = 1'b1;
          mm_wdata[d]  = base + 64'(k);
          mm_req[d]    = 1'b0;
          #1;
          rst = 1'b0;
          #1;
          check({tag, "_rst_ready"},  64'(MM_ready[d]),  64'd0);
          check({tag, "_rst_rvalid"}, 64'(mm_rvalid[d]), 64'd0);
          check({tag, "_rst_done"},   64'(mm_done[d]),   64'd0);
          check({tag, "_rst_busy"},   64'(busy[d]),      64'd0);
          check({tag, "_rst_rdata"},  mm_rdata[d],       64'd0);
          @(negedge clk);
          check({tag, "_rst_hold_done"}, 64'(mm_done[d]), 64'd0);
          mm_wvalid[d] = 1'b0;
          rst = 1'b1;
          @(negedge clk);
          check({tag, "_post_rst_done"}, 64'(mm_done[d]), 64'd0);
          check({tag, "_post_rst_busy"}, 64'(busy[d]),    64'd0);
          return;
        end else if (k == stall_at && stalls < stall_len) begin
          mm_wvalid[d] = 1'b0;
          mm_wdata[d]  = JUNK;
          stalls++;
        end else begin
          mm_wvalid[d] = 1'b1;
          mm_wdata[d]  = base + 64'(k);
          model[d][widx(addr, k)] = base + 64'(k);
          k++;
        end
      end else begin
        // Valid strobes outside the burst must not reach storage.
        mm_wvalid[d] = 1'b1;
        mm_wdata[d]  = JUNK;
      end
      if (n == last) mm_req[d] = 1'b0;
    end
    @(negedge clk);
    mm_wvalid[d] = 1'b0;
    check({tag, "_beats"},      64'(k),           64'd8);
    check({tag, "_done_after"}, 64'(mm_done[d]),  64'd0);
    check({tag, "_idle_after"}, 64'(busy[d]),     64'd0);
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mm_req[d]    = 1'b0;
      mm_we[d]     = 1'b0;
      mm_addr[d]   = '0;
      mm_wdata[d]  = '0;
      mm_wvalid[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ready",  64'(MM_ready[d]),  64'd0);
      check("reset_rvalid", 64'(mm_rvalid[d]), 64'd0);
      check("reset_done",   64'(mm_done[d]),   64'd0);
      check("reset_busy",   64'(busy[d]),      64'd0);
      check("reset_rdata",  mm_rdata[d],       64'd0);
    end
    rst = 1'b1;

    // Preload lines 0 and 1 with word i = i.
    writeback(0, 32'h0000_0000, 64'd0, -1, 0, -1, "pre_l0");
    writeback(0, 32'h0000_0040, 64'd8, -1, 0, -1, "pre_l1");
    refill(0, 32'h0000_0040, "refill_l1");

    writeback(0, 32'h0000_0080, 64'hA0, -1, 0, -1, "wb_a0");
    refill(0, 32'h0000_0080, "refill_a0");

    writeback(0, 32'h0000_00C0, 64'h50, 3, 3, -1, "wb_stall");
    refill(0, 32'h0000_00C0, "refill_stall");

    refill(0, 32'h0000_8000, "wrap");

    writeback(0, 32'h0000_0100, 64'hB0, -1, 0, -1, "wb_old");
    writeback(0, 32'h0000_0100, 64'hC0, -1, 0, 4, "wb_abort");
    refill(0, 32'h0000_0100, "refill_abort");

    writeback(1, 32'h0000_0040, 64'h70, -1, 0, -1, "lat0_wb");
    refill(1, 32'h0000_0040, "lat0_refill");

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
